// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
//   arb_state_t : arbiter state (IDLE = no owner, OWN = owner held)
//   cnt_w()     : width of the burst counter for a given maximum burst
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Burst counter must be able to hold values 0..max_burst.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index searched first; the search wraps modulo NUM_REQ
//   found : at least one request is high
//   idx   : first requesting index at or after ptr (cyclically)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    logic [IDX_W:0] k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = {1'b0, ptr} + (IDX_W+1)'(i);
            if (k >= (IDX_W+1)'(NUM_REQ)) begin
                k = k - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[k[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among
// NUM_REQ producers. An owner keeps the port for up to MAX_BURST words so
// its words land contiguously; writes are throttled by fifo_full.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-requester write request (data held until gnt)
//   req_data     : packed request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          : one-hot accept strobe, high when the word is written
//   fifo_full    : FIFO full flag
//   fifo_wr_en   : FIFO write enable
//   fifo_wr_data : FIFO write data
//   active_id    : current owner index
//   busy         : an owner is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    active_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);

    arb_state_t       state;
    logic [IDX_W-1:0] own;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic                  owning;
    logic                  wr;
    logic                  burst_last;
    logic                  rel;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owning     = (state == OWN);
    assign wr         = owning & req[own] & ~fifo_full;
    assign burst_last = (cnt == CNT_W'(MAX_BURST-1));
    assign rel        = owning & ((wr & burst_last) | ~req[own]);

    // While owning, ptr is own+1, so the previous owner is searched last.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= OWN;
                        own   <= pick_idx;
                        ptr   <= next_idx(pick_idx);
                        cnt   <= '0;
                    end
                end
                OWN: begin
                    if (rel) begin
                        // Re-pick in the same edge: handover has no idle bubble.
                        if (pick_found) begin
                            own <= pick_idx;
                            ptr <= next_idx(pick_idx);
                        end else begin
                            state <= IDLE;
                        end
                        cnt <= '0;
                    end else if (wr) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so a burst interrupted by
    // reset never writes in the reset cycle.
    assign fifo_wr_en   = ~rst & wr;
    assign gnt          = (~rst & wr) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << own) : '0;
    assign fifo_wr_data = (~rst & owning) ? words[own] : '0;
    assign active_id    = rst ? '0 : own;
    assign busy         = ~rst & owning;

endmodule
